pillar_lower_animator: RTL and testbench

PILLAR_LOWER_ANIMATOR -- requirements
Module: pillar_lower_animator

---
 rtl/pillar_lower_animator.sv | 104 ++++++++++
 tb/tb_pillar_lower_animator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pillar_lower_animator.sv
// Lowers a pillar sprite 3 pixels per frame over 26 redraws, uncovering the vacated rows with background
// and handing off to an external sprite drawer between frames. Pixels take a 2-cycle setup/plot sequence.
module pillar_lower_animator (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       frame_tick,
  input  logic [7:0] char_y,
  input  logic [2:0] pillar_color,
  input  logic [2:0] bg_color,
  input  logic       sprite_done,
  output logic [4:0] rom_x,
  output logic [4:0] rom_y,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot,
  output logic       sprite_req,
  output logic [7:0] char_y_out,
  output logic [4:0] steps,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, DRAW, CHAR, WAIT, DONE} state_t;

  localparam logic [4:0] LAST_COL  = 5'd19;
  localparam logic [4:0] LAST_ROW  = 5'd25;
  localparam logic [4:0] LAST_STEP = 5'd25;

  state_t     state;
  logic [4:0] col;
  logic [4:0] row;
  logic [7:0] step_off;
  logic [7:0] ytop;
  logic [4:0] py;
  logic       use_bg;

  // Within DRAW, vga_plot doubles as the phase bit: 0 = SETUP, 1 = PLOT.
  always_ff @(posedge clock) begin
    if (!resetn || (state != IDLE && !start)) begin
      state      <= IDLE;
      steps      <= 5'd0;
      col        <= 5'd0;
      row        <= 5'd0;
      vga_plot   <= 1'b0;
      sprite_req <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= DRAW;
        DRAW: begin
          vga_plot <= !vga_plot;
          if (vga_plot) begin
            if (col == LAST_COL) begin
              col <= 5'd0;
              if (row == LAST_ROW) begin
                row        <= 5'd0;
                state      <= CHAR;
                sprite_req <= 1'b1;
              end else begin
                row <= row + 5'd1;
              end
            end else begin
              col <= col + 5'd1;
            end
          end
        end
        CHAR: if (sprite_done) begin
          state      <= WAIT;
          sprite_req <= 1'b0;
        end
        WAIT: begin
          if (steps == LAST_STEP) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (frame_tick) begin
            steps <= steps + 5'd1;
            state <= DRAW;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign step_off   = {3'b000, steps} + {2'b00, steps, 1'b0};
  assign ytop       = 8'd77 + step_off;
  assign char_y_out = char_y + step_off;

  // Region starts 3 rows above the pillar so the rows it just vacated get repainted.
  assign vga_x = 9'd116 + {4'b0000, col};
  assign vga_y = ytop - 8'd3 + {3'b000, row};
  assign rom_x = col;
  assign rom_y = (row >= 5'd3) ? (row - 5'd3) : 5'd0;

  // Rounded cap: the top 9 pillar rows keep background outside a widening triangle.
  assign py     = row - 5'd3;
  assign use_bg = (row < 5'd3) ||
                  ((py < 5'd9) && ((col > 5'd9 + py) || (col < 5'd9 - py)));

  assign vga_color = vga_plot ? (use_bg ? bg_color : pillar_color) : 3'd0;

endmodule

// File: tb/tb_pillar_lower_animator.sv
module tb_pillar_lower_animator;

  logic       clock = 1'b0;
  logic       resetn, start, frame_tick, sprite_done;
  logic [7:0] char_y;
  logic [2:0] pillar_color = 3'd0, bg_color = 3'd0;
  logic [4:0] rom_x, rom_y, steps;
  logic [8:0] vga_x;
  logic [7:0] vga_y, char_y_out;
  logic [2:0] vga_color;
  logic       vga_plot, sprite_req, done;

  int errors = 0;
  int checks = 0;
  int overlap = 0;
  int qx[$], qy[$], qc[$];
  bit rom_mode = 1'b0;
  int rseed = 0;

  pillar_lower_animator dut (
    .clock(clock), .resetn(resetn), .start(start), .frame_tick(frame_tick),
    .char_y(char_y), .pillar_color(pillar_color), .bg_color(bg_color),
    .sprite_done(sprite_done), .rom_x(rom_x), .rom_y(rom_y), .vga_x(vga_x),
    .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
    .sprite_req(sprite_req), .char_y_out(char_y_out), .steps(steps), .done(done)
  );

  always #5 clock = ~clock;

  function automatic int prom(int x, int y);
    return rom_mode ? ((x * 7 + y * 3 + rseed) % 8) : 5;
  endfunction

  function automatic int brom(int x, int y);
    return rom_mode ? ((x * 5 + y * 11 + rseed + 3) % 8) : 1;
  endfunction

  // Synchronous ROMs: data follows the address by one clock.
  always @(posedge clock) begin
    pillar_color <= 3'(prom(int'(rom_x), int'(rom_y)));
    bg_color     <= 3'(brom(int'(vga_x), int'(vga_y)));
  end

  always @(negedge clock) begin
    if (vga_plot) begin
      qx.push_back(int'(vga_x));
      qy.push_back(int'(vga_y));
      qc.push_back(int'(vga_color));
    end
    if (vga_plot && sprite_req) overlap++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_color(int s, int col, int row);
    int x, y, py;
    x = 116 + col;
    y = 77 + 3 * s - 3 + row;
    if (row < 3) return brom(x, y);
    py = row - 3;
    if (py < 9 && (col > 9 + py || col < 9 - py)) return brom(x, y);
    return prom(col, py);
  endfunction

  task automatic check_draw(input int s);
    int bad = 0;
    int first = -1;
    chk($sformatf("plot_count_s%0d", s), qx.size(), 520);
    for (int i = 0; i < 520 && i < qx.size(); i++) begin
      int c, r;
      c = i % 20;
      r = i / 20;
      if (qx[i] != 116 + c || qy[i] != 74 + 3 * s + r || qc[i] != exp_color(s, c, r)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("pixels_s%0d_first_bad_%0d", s, first), bad, 0);
  endtask

  // Trigger (start or frame_tick) must already be set; optionally pulses a stray tick mid-draw.
  task automatic run_draw(input int s, input bit inject);
    int cyc = -1;
    int tick_at;
    tick_at = int'($urandom_range(1000, 5));
    qx.delete(); qy.delete(); qc.delete();
    for (int i = 1; i <= 1200; i++) begin
      @(posedge clock); #1;
      frame_tick = inject && (i == tick_at);
      if (sprite_req) begin
        cyc = i;
        break;
      end
    end
    frame_tick = 1'b0;
    chk($sformatf("draw_cycles_s%0d", s), cyc, 1041);
    check_draw(s);
    chk($sformatf("steps_s%0d", s), int'(steps), s);
    chk($sformatf("char_y_out_s%0d", s), int'(char_y_out), (int'(char_y) + 3 * s) % 256);
  endtask

  task automatic finish_char();
    repeat ($urandom_range(20, 0)) @(posedge clock);
    #1 sprite_done = 1'b1;
    @(posedge clock); #1;
    sprite_done = 1'b0;
    chk("sprite_req_release", int'(sprite_req), 0);
  endtask

  task automatic tick();
    repeat ($urandom_range(5, 1)) @(posedge clock);
    #1 frame_tick = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b1; frame_tick = 1'b1; sprite_done = 1'b0; char_y = 8'd60;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_vga_x", int'(vga_x), 116);
    chk("rst_vga_y", int'(vga_y), 74);
    chk("rst_vga_plot", int'(vga_plot), 0);
    chk("rst_vga_color", int'(vga_color), 0);
    chk("rst_sprite_req", int'(sprite_req), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_steps", int'(steps), 0);
    chk("rst_rom_xy", int'({rom_x, rom_y}), 0);
    start = 1'b0; frame_tick = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (3) @(posedge clock);
    #1 chk("idle_no_plot", qx.size(), 0);

    // Constant ROM data: directed pixel spot checks on the first draw.
    start = 1'b1;
    run_draw(0, 1'b0);
    if (qx.size() == 520) begin
      chk("first_plot_xyc", qx[0] * 10000 + qy[0] * 10 + qc[0], 116 * 10000 + 74 * 10 + 1);
      chk("r3c9_xyc", qx[69] * 10000 + qy[69] * 10 + qc[69], 125 * 10000 + 77 * 10 + 5);
      chk("r3c0_xyc", qx[60] * 10000 + qy[60] * 10 + qc[60], 116 * 10000 + 77 * 10 + 1);
      chk("last_plot_xy", qx[519] * 1000 + qy[519], 135 * 1000 + 99);
    end else begin
      chk("first_draw_size", qx.size(), 520);
    end

    // Sprite drawer stalls; stray tick in CHAR ignored.
    qx.delete();
    repeat (50) @(posedge clock);
    #1 frame_tick = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0;
    repeat (49) @(posedge clock);
    #1;
    chk("char_hold_req", int'(sprite_req), 1);
    chk("char_no_plot", qx.size(), 0);
    chk("char_tick_ignored", int'(steps), 0);
    finish_char();
    repeat (50) @(posedge clock);
    #1;
    chk("wait_no_plot", qx.size(), 0);
    chk("wait_steps", int'(steps), 0);

    // Randomised ROM contents for the full lowering run.
    rom_mode = 1'b1;
    rseed = int'($urandom_range(7, 0));
    for (int s = 1; s <= 25; s++) begin
      char_y = (s == 25) ? 8'd60 : 8'($urandom);
      tick();
      run_draw(s, 1'b1);
      finish_char();
    end
    @(posedge clock); #1;
    chk("done_flag", int'(done), 1);
    chk("done_steps", int'(steps), 25);
    chk("done_char_y_out", int'(char_y_out), 135);
    qx.delete();
    tick();
    @(posedge clock); #1 frame_tick = 1'b0;
    repeat (1100) @(posedge clock);
    #1;
    chk("no_27th_draw", qx.size(), 0);
    chk("done_held", int'(done), 1);

    // Abort mid-draw at steps 7, then restart from the top.
    start = 1'b0;
    @(posedge clock); #1;
    chk("abort_done_clear", int'(done), 0);
    chk("abort_steps_clear", int'(steps), 0);
    start = 1'b1;
    run_draw(0, 1'b0);
    for (int s = 1; s <= 6; s++) begin
      finish_char();
      tick();
      run_draw(s, 1'b0);
    end
    finish_char();
    tick();
    @(posedge clock); #1 frame_tick = 1'b0;
    repeat ($urandom_range(900, 100)) @(posedge clock);
    #1;
    chk("mid_draw_steps7", int'(steps), 7);
    start = 1'b0;
    @(posedge clock); #1;
    chk("abort_plot", int'(vga_plot), 0);
    chk("abort_steps", int'(steps), 0);
    chk("abort_vga_xy", int'(vga_x) * 1000 + int'(vga_y), 116 * 1000 + 74);
    start = 1'b1;
    run_draw(0, 1'b0);

    chk("req_plot_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
